mem_lsu_stage: RTL and testbench
================================

// Module: mem_lsu_stage
// PURPOSE
//  MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.
//  Consumes ALU address, rs2 store data, lsu_op and mem_wren from EX/MEM.
//  Runs a req/ack transaction on the data-memory port, stalling the pipeline until done.
//  Returns aligned, sign/zero-extended load data to the MEM/WB path; flags misalignment and bus timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  16  BUSY cycles without i_dmem_ack before abort; must be >=1.
//  TO_CNT_W        $clog2(TIMEOUT_CYCLES+1)  timeout counter width (derived, do not override).
// PORTS
//  i_clk          in   1   clock, all state updates on rising edge
//  i_reset_mem    in   1   synchronous reset, active-high
//  i_inst_vld     in   1   instruction in MEM stage is valid
//  i_mem_wren     in   1   1=store, 0=load (qualified by i_lsu_op[3])
//  i_lsu_op       in   4   [3]=access enable, [2]=unsigned load, [1:0]=size 00 B/01 H/10 W/11 illegal
//  i_alu_data     in   32  byte address
//  i_rs2_data     in   32  store data (LSB-justified)
//  i_dmem_ack     in   1   one-cycle completion strobe; i_dmem_rdata valid same cycle
//  i_dmem_rdata   in   32  word-aligned read data
//  o_dmem_req     out  1   request, held high until ack or timeout
//  o_dmem_we      out  1   write enable
//  o_dmem_addr    out  32  {i_alu_data[31:2],2'b00}
//  o_dmem_be      out  4   byte enables
//  o_dmem_wdata   out  32  lane-replicated store data
//  o_ld_data      out  32  extended load result
//  o_stall        out  1   hold EX/MEM and earlier stages
//  o_misalign     out  1   one-cycle pulse: misaligned or illegal-size access, not issued
//  o_bus_err      out  1   one-cycle pulse: access aborted on timeout
// BEHAVIOUR
//  Reset: state IDLE, counter 0; all registered outputs 0; o_stall forced 0 while i_reset_mem=1.
//  Reset mid-transaction: o_dmem_req low the cycle after reset asserts; late ack ignored.
//  access = i_inst_vld & i_lsu_op[3]. bad = size 11 | (H & a[0]) | (W & a[1:0]!=0).
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: access&!bad -> o_stall=1 (comb), latch addr/we/be/wdata, req=1 next cycle, go BUSY.
//         access&bad  -> o_misalign=1 next cycle, no req, no stall, o_ld_data<=0, stay IDLE.
//         i_dmem_ack in IDLE ignored.
//   BUSY: o_stall=1; req/we/addr/be/wdata stable. On ack: req<=0, load -> o_ld_data<=extract(rdata),
//         go DONE. Counter increments each BUSY cycle without ack; at TIMEOUT_CYCLES: req<=0,
//         o_bus_err<=1 (one cycle), o_ld_data<=0, go DONE. Ack on the timeout cycle wins (no error).
//   DONE: o_stall=0 (EX/MEM advances on this edge); counter<=0; go IDLE unconditionally.
//  Minimum penalty: ack in first BUSY cycle -> o_stall high exactly 2 cycles.
//  o_stall = (IDLE & access & !bad) | BUSY.
//  Stores: B be=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}; H be=4'b0011<<a[1:0], wdata={2{rs2[15:0]}};
//          W be=4'hF, wdata=rs2. o_ld_data unchanged by stores. [2] ignored for stores.
//  Loads: be=4'hF, we=0. B byte=rdata[8*a[1:0]+:8], H half=rdata[16*a[1]+:16];
//         sign-extend if [2]=0, zero-extend if [2]=1; W passes rdata.
//  o_ld_data holds value until next completed/aborted/misaligned load.
// TESTING
//  LW a=0x100, ack 1st BUSY cycle rdata=0xDEADBEEF -> req 1 cyc, stall 2 cyc, o_ld_data=0xDEADBEEF.
//  LB a=0x103 rdata=0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LH a=0x102 -> 0xFFFF8011.
//  SB a=0x2, rs2=0x000000A5 -> be=4'b0100, wdata=0xA5A5A5A5, we=1, addr=0x0.
//  LW a=0x101 -> o_misalign pulse, o_dmem_req never high, o_stall never high.
//  No ack, TIMEOUT_CYCLES=16 -> req high 16 cyc, o_bus_err pulse, o_ld_data=0, stall drops in DONE.
//  Reset asserted 3 cycles into BUSY, then ack -> req 0 next cycle, state IDLE, ack ignored, outputs 0.

Source files
------------

// File: rtl/mem_lsu_stage_if.sv
// ----------------------------------------------------------------------------
// mem_lsu_stage_if
// Purpose : Groups the MEM-stage load/store unit's pipeline-facing inputs, its
//           data-memory port and its result/status outputs into one bundle.
// Signals (names are as seen from the load/store unit):
//   i_inst_vld, i_mem_wren, i_lsu_op[3:0], i_alu_data[31:0], i_rs2_data[31:0]
//                                   : instruction fields from EX/MEM
//   i_dmem_ack, i_dmem_rdata[31:0]  : data-memory completion strobe and read data
//   o_dmem_req, o_dmem_we, o_dmem_addr[31:0], o_dmem_be[3:0], o_dmem_wdata[31:0]
//                                   : data-memory request
//   o_ld_data[31:0], o_stall, o_misalign, o_bus_err
//                                   : result and status back to the pipeline
// Handshake: o_dmem_req rises with we/addr/be/wdata valid and all of them stay
//   stable until the cycle in which i_dmem_ack is high (a single-cycle strobe
//   carrying i_dmem_rdata) or the unit gives up on timeout; req drops on the
//   following edge. An ack while no request is outstanding is ignored.
// Modports: slave = load/store unit, master = pipeline plus memory side.
// ----------------------------------------------------------------------------
interface mem_lsu_stage_if;
    logic        i_inst_vld;
    logic        i_mem_wren;
    logic [3:0]  i_lsu_op;
    logic [31:0] i_alu_data;
    logic [31:0] i_rs2_data;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic [31:0] o_ld_data;
    logic        o_stall;
    logic        o_misalign;
    logic        o_bus_err;

    modport slave (
        input  i_inst_vld, i_mem_wren, i_lsu_op, i_alu_data, i_rs2_data,
        input  i_dmem_ack, i_dmem_rdata,
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        output o_ld_data, o_stall, o_misalign, o_bus_err
    );

    modport master (
        output i_inst_vld, i_mem_wren, i_lsu_op, i_alu_data, i_rs2_data,
        output i_dmem_ack, i_dmem_rdata,
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
        input  o_ld_data, o_stall, o_misalign, o_bus_err
    );
endinterface

// File: rtl/mem_lsu_stage.sv
// ----------------------------------------------------------------------------
// mem_lsu_stage
// Purpose : MEM-stage load/store unit. Takes address, store data and op from
//           EX/MEM, runs one req/ack transaction on the data-memory port while
//           stalling the pipeline, and returns aligned, extended load data.
//           Misaligned/illegal-size accesses are flagged and never issued; a
//           request with no ack for TIMEOUT_CYCLES cycles is aborted.
// Ports   :
//   i_clk        : clock, rising edge
//   i_reset_mem  : synchronous reset, active-high
//   bus          : mem_lsu_stage_if.slave (pipeline fields, dmem port, results)
//   o_dbg_state  : current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ----------------------------------------------------------------------------
module mem_lsu_stage #(
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int TO_CNT_W       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_mem,
    mem_lsu_stage_if.slave        bus,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TO_CNT_W-1:0] r_cnt;

    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_ld_data;
    logic        r_misalign;
    logic        r_bus_err;
    // Access shape kept for the load extraction when the ack arrives.
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_uns;

    logic        w_access;
    logic        w_bad;
    logic [1:0]  w_size;
    logic [1:0]  w_off;
    logic        w_stall;
    logic        w_timeout;
    logic [3:0]  w_be_issue;
    logic [31:0] w_wdata_issue;
    logic [31:0] w_rd_shift;
    logic [31:0] w_ld_ext;

    assign w_access  = bus.i_inst_vld & bus.i_lsu_op[3];
    assign w_size    = bus.i_lsu_op[1:0];
    assign w_off     = bus.i_alu_data[1:0];
    assign w_bad     = (w_size == 2'b11)
                     | ((w_size == 2'b01) & w_off[0])
                     | ((w_size == 2'b10) & (w_off != 2'b00));
    // Last BUSY cycle allowed without an ack; an ack in this cycle still wins.
    assign w_timeout = (r_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

    // Byte enables and lane-replicated write data for the access being issued.
    always_comb begin
        w_be_issue    = 4'hF;
        w_wdata_issue = 32'h0;
        if (bus.i_mem_wren) begin
            case (w_size)
                2'b00: begin
                    w_be_issue    = 4'b0001 << w_off;
                    w_wdata_issue = {4{bus.i_rs2_data[7:0]}};
                end
                2'b01: begin
                    w_be_issue    = 4'b0011 << w_off;
                    w_wdata_issue = {2{bus.i_rs2_data[15:0]}};
                end
                default: begin
                    w_be_issue    = 4'hF;
                    w_wdata_issue = bus.i_rs2_data;
                end
            endcase
        end
    end

    // Move the addressed byte/half down to bit 0, then extend.
    assign w_rd_shift = bus.i_dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ld_ext = bus.i_dmem_rdata;
        case (r_size)
            2'b00:   w_ld_ext = r_uns ? {24'h0, w_rd_shift[7:0]}
                                      : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            2'b01:   w_ld_ext = r_uns ? {16'h0, w_rd_shift[15:0]}
                                      : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_ld_ext = bus.i_dmem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset_mem) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and stall
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && !w_bad) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (bus.i_dmem_ack || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Stall is released here so EX/MEM advances on this edge.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_reset_mem) begin
            w_stall = 1'b0;
        end
    end

    // Datapath and status registers
    always_ff @(posedge i_clk) begin
        if (i_reset_mem) begin
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_be       <= 4'h0;
            r_wdata    <= 32'h0;
            r_ld_data  <= 32'h0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            r_off      <= 2'b00;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_bad) begin
                            r_misalign <= 1'b1;
                            // Stores never touch the load result.
                            if (!bus.i_mem_wren) begin
                                r_ld_data <= 32'h0;
                            end
                        end else begin
                            r_req   <= 1'b1;
                            r_we    <= bus.i_mem_wren;
                            r_addr  <= {bus.i_alu_data[31:2], 2'b00};
                            r_be    <= w_be_issue;
                            r_wdata <= w_wdata_issue;
                            r_off   <= w_off;
                            r_size  <= w_size;
                            r_uns   <= bus.i_lsu_op[2];
                            r_cnt   <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.i_dmem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_ld_data <= w_ld_ext;
                        end
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_we) begin
                            r_ld_data <= 32'h0;
                        end
                    end else begin
                        r_cnt <= r_cnt + TO_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.o_dmem_req   = r_req;
    assign bus.o_dmem_we    = r_we;
    assign bus.o_dmem_addr  = r_addr;
    assign bus.o_dmem_be    = r_be;
    assign bus.o_dmem_wdata = r_wdata;
    assign bus.o_ld_data    = r_ld_data;
    assign bus.o_stall      = w_stall;
    assign bus.o_misalign   = r_misalign;
    assign bus.o_bus_err    = r_bus_err;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mem_lsu_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_lsu_stage
// Bench for mem_lsu_stage. The driver plays the pipeline and the memory: for
// each instruction it knows how many BUSY cycles the memory withholds its ack,
// derives from that what every output must show in every cycle, and queues one
// expected record per cycle. A single compare process checks the DUT against
// the queue on the falling edge. A few hand-computed literals pin the model.
// ----------------------------------------------------------------------------
module tb_mem_lsu_stage;

    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    mem_lsu_stage_if bus ();

    mem_lsu_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (clk),
        .i_reset_mem (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        stall;
        logic        req;
        logic        chk_bus;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // model state
    logic [31:0] ld_model = 32'h0;
    logic        pend_mis = 1'b0;
    logic        m_we     = 1'b0;
    logic [31:0] m_addr   = 32'h0;
    logic [3:0]  m_be     = 4'h0;
    logic [31:0] m_wdata  = 32'h0;

    // activity counters for literal checks
    int          req_cyc  = 0;
    int          stall_cyc = 0;
    int          berr_cyc = 0;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_dmem_req) begin
            req_cyc++;
            cap_we    = bus.o_dmem_we;
            cap_addr  = bus.o_dmem_addr;
            cap_be    = bus.o_dmem_be;
            cap_wdata = bus.o_dmem_wdata;
        end
        if (bus.o_stall)   stall_cyc++;
        if (bus.o_bus_err) berr_cyc++;
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall",    {31'h0, bus.o_stall},    {31'h0, e.stall});
            chk("req",      {31'h0, bus.o_dmem_req}, {31'h0, e.req});
            chk("ld_data",  bus.o_ld_data,           e.ld);
            chk("misalign", {31'h0, bus.o_misalign}, {31'h0, e.mis});
            chk("bus_err",  {31'h0, bus.o_bus_err},  {31'h0, e.berr});
            if (e.chk_bus) begin
                chk("we",   {31'h0, bus.o_dmem_we},  {31'h0, e.we});
                chk("addr", bus.o_dmem_addr,         e.addr);
                chk("be",   {28'h0, bus.o_dmem_be},  {28'h0, e.be});
                if (e.we) chk("wdata", bus.o_dmem_wdata, e.wdata);
            end
        end
    end

    // ---------------- model helpers ----------------
    function automatic logic [31:0] ext(input logic [31:0] rd, input logic [31:0] a,
                                        input logic [3:0] op);
        int unsigned v;
        int unsigned off;
        off = a % 4;
        case (op[1:0])
            2'b00: begin
                v = (rd >> (8 * off)) % 256;
                if (!op[2] && v >= 128) v = v + 32'hFFFFFF00;
            end
            2'b01: begin
                v = (rd >> (16 * (off / 2))) % 65536;
                if (!op[2] && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic stall, input logic req, input logic chk_bus,
                        input logic berr);
        exp_t r;
        r.stall = stall; r.req = req; r.chk_bus = chk_bus;
        r.we = m_we; r.addr = m_addr; r.be = m_be; r.wdata = m_wdata;
        r.ld = ld_model; r.mis = pend_mis; r.berr = berr;
        exp_q.push_back(r);
        pend_mis = 1'b0;
    endtask

    // One instruction through MEM. d = BUSY cycles without ack before the ack;
    // d >= TO means the memory never answers.
    task automatic run_txn(input logic vld, input logic wren, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] rs2,
                           input logic [31:0] rd, input int d);
        logic access, bad;
        int unsigned off, n;
        bus.i_inst_vld = vld;  bus.i_mem_wren = wren; bus.i_lsu_op = op;
        bus.i_alu_data = a;    bus.i_rs2_data = rs2;
        access = vld & op[3];
        off    = a % 4;
        bad    = (op[1:0] == 2'b11) || (op[1:0] == 2'b01 && off % 2 != 0) ||
                 (op[1:0] == 2'b10 && off != 0);
        if (!access || bad) begin
            // memory strobes at random here; nothing is outstanding
            bus.i_dmem_ack   = 1'($urandom_range(0, 1));
            bus.i_dmem_rdata = $urandom;
            push(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            bus.i_dmem_ack = 1'b0;
            if (access) begin
                pend_mis = 1'b1;
                if (!wren) ld_model = 32'h0;
            end
        end else begin
            m_we   = wren;
            m_addr = a - off;
            if (!wren) begin
                m_be = 4'hF; m_wdata = 32'h0;
            end else if (op[1:0] == 2'b00) begin
                m_be = 4'(1 << off); m_wdata = (rs2 % 256) * 32'h01010101;
            end else if (op[1:0] == 2'b01) begin
                m_be = 4'(3 << off); m_wdata = (rs2 % 65536) * 32'h00010001;
            end else begin
                m_be = 4'hF; m_wdata = rs2;
            end
            push(1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            n = (d >= TO) ? TO : d + 1;
            for (int i = 1; i <= int'(n); i++) begin
                bus.i_dmem_ack   = (i == int'(n)) && (d < TO);
                bus.i_dmem_rdata = (i == int'(n)) ? rd : $urandom;
                push(1'b1, 1'b1, 1'b1, 1'b0);
                tick();
            end
            bus.i_dmem_ack = 1'b0;
            if (!wren) ld_model = (d >= TO) ? 32'h0 : ext(rd, a, op);
            push(1'b0, 1'b0, 1'b0, d >= TO);
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    int rc0, sc0, bc0;

    initial begin
        rst = 1'b1;
        // a valid, well-formed load is presented during reset: stall must stay low
        bus.i_inst_vld = 1'b1; bus.i_mem_wren = 1'b0; bus.i_lsu_op = 4'b1010;
        bus.i_alu_data = 32'h0; bus.i_rs2_data = 32'h0;
        bus.i_dmem_ack = 1'b0;  bus.i_dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'h0, bus.o_stall},    32'h0);
        chk("rst_req",   {31'h0, bus.o_dmem_req}, 32'h0);
        chk("rst_we",    {31'h0, bus.o_dmem_we},  32'h0);
        chk("rst_addr",  bus.o_dmem_addr,         32'h0);
        chk("rst_be",    {28'h0, bus.o_dmem_be},  32'h0);
        chk("rst_wdata", bus.o_dmem_wdata,        32'h0);
        chk("rst_ld",    bus.o_ld_data,           32'h0);
        chk("rst_flags", {30'h0, bus.o_misalign, bus.o_bus_err}, 32'h0);
        chk("rst_state", {30'h0, dbg_state},      32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LW 0x100, ack in first BUSY cycle
        rc0 = req_cyc; sc0 = stall_cyc;
        run_txn(1, 0, 4'b1010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        chk("lw_ld",        bus.o_ld_data,     32'hDEADBEEF);
        chk("lw_req_cyc",   req_cyc - rc0,     32'd1);
        chk("lw_stall_cyc", stall_cyc - sc0,   32'd2);

        // misaligned LW: never issued, never stalls
        rc0 = req_cyc; sc0 = stall_cyc;
        run_txn(1, 0, 4'b1010, 32'h101, 32'h0, 32'h0, 0);
        run_txn(0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 0);
        chk("mis_req_cyc",   req_cyc - rc0,   32'd0);
        chk("mis_stall_cyc", stall_cyc - sc0, 32'd0);
        chk("mis_ld",        bus.o_ld_data,   32'h0);

        // sub-word loads
        run_txn(1, 0, 4'b1000, 32'h103, 32'h0, 32'h80112233, 1);
        chk("lb_ld",  bus.o_ld_data, 32'hFFFFFF80);
        run_txn(1, 0, 4'b1100, 32'h103, 32'h0, 32'h80112233, 0);
        chk("lbu_ld", bus.o_ld_data, 32'h00000080);
        run_txn(1, 0, 4'b1001, 32'h102, 32'h0, 32'h80112233, 3);
        chk("lh_ld",  bus.o_ld_data, 32'hFFFF8011);

        // SB leaves the load result alone
        run_txn(1, 1, 4'b1000, 32'h2, 32'h000000A5, 32'h0, 2);
        chk("sb_we",    {31'h0, cap_we},   32'h1);
        chk("sb_addr",  cap_addr,          32'h0);
        chk("sb_be",    {28'h0, cap_be},   32'h4);
        chk("sb_wdata", cap_wdata,         32'hA5A5A5A5);
        chk("sb_ld",    bus.o_ld_data,     32'hFFFF8011);

        // no ack: abort after TO BUSY cycles
        rc0 = req_cyc; sc0 = stall_cyc; bc0 = berr_cyc;
        run_txn(1, 0, 4'b1010, 32'h40, 32'h0, 32'h12345678, 100);
        chk("to_req_cyc",   req_cyc - rc0,   TO);
        chk("to_stall_cyc", stall_cyc - sc0, TO + 1);
        chk("to_berr_cyc",  berr_cyc - bc0,  32'd1);
        chk("to_ld",        bus.o_ld_data,   32'h0);

        // ack on the last permitted cycle wins over the timeout
        bc0 = berr_cyc;
        run_txn(1, 0, 4'b1010, 32'h44, 32'h0, 32'hCAFEF00D, TO - 1);
        chk("edge_ld",   bus.o_ld_data,  32'hCAFEF00D);
        chk("edge_berr", berr_cyc - bc0, 32'd0);

        // reset three cycles into BUSY, then a late ack
        bus.i_inst_vld = 1'b1; bus.i_mem_wren = 1'b0; bus.i_lsu_op = 4'b1010;
        bus.i_alu_data = 32'h200;
        m_we = 1'b0; m_addr = 32'h200; m_be = 4'hF;
        push(1'b1, 1'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 2; i++) begin
            push(1'b1, 1'b1, 1'b1, 1'b0); tick();
        end
        rst = 1'b1;
        push(1'b0, 1'b1, 1'b1, 1'b0); tick();
        rst = 1'b0;
        bus.i_inst_vld = 1'b0; bus.i_dmem_ack = 1'b1; bus.i_dmem_rdata = 32'h55AA55AA;
        ld_model = 32'h0; m_we = 1'b0; m_addr = 32'h0; m_be = 4'h0; m_wdata = 32'h0;
        chk("rst_busy_state", {30'h0, dbg_state}, 32'h0);
        push(1'b0, 1'b0, 1'b1, 1'b0); tick();
        bus.i_dmem_ack = 1'b0;
        chk("rst_ack_state", {30'h0, dbg_state}, 32'h0);
        push(1'b0, 1'b0, 1'b1, 1'b0); tick();

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            logic        vld, wren;
            logic [3:0]  op;
            int          d;
            vld  = ($urandom_range(0, 9) != 0);
            wren = 1'($urandom_range(0, 1));
            op   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op[3] = 1'b1;
            case ($urandom_range(0, 19))
                0:       d = TO + 3;
                1:       d = TO - 1;
                default: d = $urandom_range(0, 4);
            endcase
            run_txn(vld, wren, op, $urandom, $urandom, $urandom, d);
        end
        run_txn(0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 0);
        run_txn(0, 0, 4'b0000, 32'h0, 32'h0, 32'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
